mem_wb_stage: RTL and testbench

- Pipeline register and write-back selector that sits directly downstream of MEMORY in the 5-stage MIPS pipeline.
- Captures MEMORY's load data and the forwarded EX/MEM fields on every stepped clock.
- Selects the register-file write value and exposes the write port (data, rd, enable) to the register bank and the forwarding unit.
- Tracks pipeline halt and counts retired instructions for the debug unit.

---
 rtl/mem_wb_stage_if.sv | 40 ++++
 rtl/mem_wb_stage.sv | 101 ++++++++++
 tb/tb_mem_wb_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_wb_stage_if                                           |
// | Purpose  : MEM -> WB pipeline bundle and register-file write port    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface mem_wb_stage_if #(
    parameter int NB        = 32,
    parameter int NB_REG    = 5,
    parameter int NB_WB_SRC = 2,
    parameter int NB_CNT    = 32
);
    logic                 i_step;
    logic                 i_valid;
    logic                 i_halt;
    logic [NB-1:0]        i_data_memory;
    logic [NB-1:0]        i_alu_result;
    logic [NB-1:0]        i_pc_plus_8;
    logic [NB_REG-1:0]    i_rd;
    logic                 i_reg_write;
    logic [NB_WB_SRC-1:0] i_wb_src;
    logic [NB-1:0]        o_wb_data;
    logic [NB_REG-1:0]    o_wb_rd;
    logic                 o_wb_reg_write;
    logic                 o_halted;
    logic [NB_CNT-1:0]    o_retired_count;

    modport master (
        output i_step, i_valid, i_halt, i_data_memory, i_alu_result,
               i_pc_plus_8, i_rd, i_reg_write, i_wb_src,
        input  o_wb_data, o_wb_rd, o_wb_reg_write, o_halted, o_retired_count
    );

    modport slave (
        input  i_step, i_valid, i_halt, i_data_memory, i_alu_result,
               i_pc_plus_8, i_rd, i_reg_write, i_wb_src,
        output o_wb_data, o_wb_rd, o_wb_reg_write, o_halted, o_retired_count
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_wb_stage                                              |
// | Purpose  : MEM/WB pipeline register, write-back mux, halt tracking   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mem_wb_stage #(
    parameter int NB        = 32,
    parameter int NB_REG    = 5,
    parameter int NB_WB_SRC = 2,
    parameter int NB_CNT    = 32
) (
    input  wire logic     i_clk,
    input  wire logic     i_reset,
    mem_wb_stage_if.slave bus
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [NB_WB_SRC-1:0] c_SRC_MEM  = NB_WB_SRC'(1);
    localparam logic [NB_WB_SRC-1:0] c_SRC_LINK = NB_WB_SRC'(2);

    state_t               state_q,     state_d;
    logic [NB-1:0]        mem_data_q,  mem_data_d;
    logic [NB-1:0]        alu_q,       alu_d;
    logic [NB-1:0]        pc8_q,       pc8_d;
    logic [NB_REG-1:0]    rd_q,        rd_d;
    logic [NB_WB_SRC-1:0] wb_src_q,    wb_src_d;
    logic                 reg_write_q, reg_write_d;
    logic [NB_CNT-1:0]    count_q,     count_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= RUN;
            mem_data_q  <= '0;
            alu_q       <= '0;
            pc8_q       <= '0;
            rd_q        <= '0;
            wb_src_q    <= '0;
            reg_write_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_data_q  <= mem_data_d;
            alu_q       <= alu_d;
            pc8_q       <= pc8_d;
            rd_q        <= rd_d;
            wb_src_q    <= wb_src_d;
            reg_write_q <= reg_write_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_data_d  = mem_data_q;
        alu_d       = alu_q;
        pc8_d       = pc8_q;
        rd_d        = rd_q;
        wb_src_d    = wb_src_q;
        reg_write_d = reg_write_q;
        count_d     = count_q;
        // HALTED keeps every field frozen; only reset leaves it.
        if (state_q == RUN && bus.i_step) begin
            mem_data_d  = bus.i_data_memory;
            alu_d       = bus.i_alu_result;
            pc8_d       = bus.i_pc_plus_8;
            rd_d        = bus.i_rd;
            wb_src_d    = bus.i_wb_src;
            reg_write_d = bus.i_reg_write & bus.i_valid & ~bus.i_halt
                          & (bus.i_rd != '0);
            if (bus.i_valid) begin
                if (count_q != '1) begin
                    count_d = count_q + NB_CNT'(1);
                end
                if (bus.i_halt) begin
                    state_d = HALTED;
                end
            end
        end
    end

    // Source 11 aliases the ALU result, so it falls into the default arm.
    always_comb begin
        case (wb_src_q)
            c_SRC_MEM:  bus.o_wb_data = mem_data_q;
            c_SRC_LINK: bus.o_wb_data = pc8_q;
            default:    bus.o_wb_data = alu_q;
        endcase
    end

    assign bus.o_wb_rd         = rd_q;
    assign bus.o_wb_reg_write  = reg_write_q;
    assign bus.o_halted        = (state_q == HALTED);
    assign bus.o_retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mem_wb_stage                                           |
// | Purpose  : directed self-checking bench for mem_wb_stage             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_mem_wb_stage;

    logic i_clk;
    logic i_reset;
    int   n_checks;
    int   n_pass;

    mem_wb_stage_if #(.NB(32), .NB_REG(5), .NB_WB_SRC(2), .NB_CNT(32)) bus ();
    mem_wb_stage_if #(.NB(32), .NB_REG(5), .NB_WB_SRC(2), .NB_CNT(2))  bus_s ();

    mem_wb_stage #(.NB(32), .NB_REG(5), .NB_WB_SRC(2), .NB_CNT(32)) u_dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    // Narrow counter copy, driven identically, exposes saturation quickly.
    mem_wb_stage #(.NB(32), .NB_REG(5), .NB_WB_SRC(2), .NB_CNT(2)) u_dut_sat (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus_s.slave)
    );

    assign bus_s.i_step        = bus.i_step;
    assign bus_s.i_valid       = bus.i_valid;
    assign bus_s.i_halt        = bus.i_halt;
    assign bus_s.i_data_memory = bus.i_data_memory;
    assign bus_s.i_alu_result  = bus.i_alu_result;
    assign bus_s.i_pc_plus_8   = bus.i_pc_plus_8;
    assign bus_s.i_rd          = bus.i_rd;
    assign bus_s.i_reg_write   = bus.i_reg_write;
    assign bus_s.i_wb_src      = bus.i_wb_src;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic step, input logic valid, input logic halt,
                         input logic rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc8);
        bus.i_step        = step;
        bus.i_valid       = valid;
        bus.i_halt        = halt;
        bus.i_reg_write   = rw;
        bus.i_rd          = rd;
        bus.i_wb_src      = src;
        bus.i_alu_result  = alu;
        bus.i_data_memory = mem;
        bus.i_pc_plus_8   = pc8;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] data, input logic [4:0] rd,
                             input logic we, input logic halted, input logic [31:0] cnt);
        check({tag, ".data"},   bus.o_wb_data,                data);
        check({tag, ".rd"},     {27'd0, bus.o_wb_rd},         {27'd0, rd});
        check({tag, ".we"},     {31'd0, bus.o_wb_reg_write},  {31'd0, we});
        check({tag, ".halted"}, {31'd0, bus.o_halted},        {31'd0, halted});
        check({tag, ".count"},  bus.o_retired_count,          cnt);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        i_reset  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        check_out("reset", 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 2'b00, 32'h0000_0010, 32'h1234_5678, 32'h0000_0100);
        check_out("alu", 32'h0000_0010, 5'd3, 1'b1, 1'b0, 32'd1);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 2'b01, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0000_0104);
        check_out("load", 32'hA5A5_A5A5, 5'd8, 1'b1, 1'b0, 32'd2);

        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 2'b00, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 32'h0000_0200);
        check_out("nostep", 32'hA5A5_A5A5, 5'd8, 1'b1, 1'b0, 32'd2);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 2'b10, 32'h0000_0030, 32'h0000_0040, 32'h0000_0048);
        check_out("link", 32'h0000_0048, 5'd31, 1'b1, 1'b0, 32'd3);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 2'b10, 32'h0000_0030, 32'h0000_0040, 32'h0000_0048);
        check_out("link_r0", 32'h0000_0048, 5'd0, 1'b0, 1'b0, 32'd4);
        check("sat.count3", {30'd0, bus_s.o_retired_count}, 32'd3);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 2'b11, 32'h0000_0077, 32'h0000_0011, 32'h0000_0022);
        check_out("src11", 32'h0000_0077, 5'd5, 1'b1, 1'b0, 32'd5);
        check("sat.hold", {30'd0, bus_s.o_retired_count}, 32'd3);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 2'b00, 32'h0000_0066, 32'h0, 32'h0);
        check_out("bubble", 32'h0000_0066, 5'd6, 1'b0, 1'b0, 32'd5);

        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 2'b00, 32'h0000_0099, 32'h0, 32'h0);
        check_out("halt", 32'h0000_0099, 5'd4, 1'b0, 1'b1, 32'd6);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 2'b01, 32'h0000_0055, 32'h0000_00AA, 32'h0);
        end
        check_out("frozen", 32'h0000_0099, 5'd4, 1'b0, 1'b1, 32'd6);

        #2;
        i_reset = 1'b0;
        #1;
        check_out("async_rst", 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 2'b00, 32'h0000_0123, 32'h0, 32'h0);
        check_out("rerun", 32'h0000_0123, 5'd2, 1'b1, 1'b0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
